pc_sequencer: RTL

- Owns the architectural fetch PC for the 5-stage pipeline and sequences it each cycle.
- Arbitrates between redirect (taken branch/jump from EX), hazard stall (from the hazard unit), instruction-memory wait, and halt.
- Drives IF-stage valid and the IF/ID and ID/EX flush strobes.
- Keeps saturating performance counters for stall and flush cycles.

---
 rtl/pipeline_pkg.sv | 19 +
 rtl/sat_counter.sv | 24 ++
 rtl/pc_sequencer.sv | 122 ++++++++++++
 3 files changed

// File: rtl/pipeline_pkg.sv
`default_nettype none
// +--------------------------------------------------------------+
// | pipeline_pkg : shared fetch-sequencer state type and defaults |
// | Revision     : 1.0                                           |
// +--------------------------------------------------------------+
package pipeline_pkg;

   localparam int          DEF_XLEN     = 32;
   localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;

   typedef enum logic [1:0] {
      ST_BOOT  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FLUSH = 2'd2,
      ST_HALT  = 2'd3
   } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// +--------------------------------------------------------------+
// | sat_counter : enable-driven up-counter that sticks at max    |
// | Revision    : 1.0                                            |
// +--------------------------------------------------------------+
module sat_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   output logic [W-1:0] cnt
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (en && (cnt != {W{1'b1}})) begin
         cnt <= cnt + W'(1);
      end
   end

endmodule
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------+
// | pc_sequencer : fetch PC owner with redirect/stall/halt arb.  |
// | Revision     : 1.0                                           |
// +--------------------------------------------------------------+
module pc_sequencer
   import pipeline_pkg::*;
#(
   parameter int              XLEN         = DEF_XLEN,
   parameter logic [XLEN-1:0] RESET_PC     = XLEN'(DEF_RESET_PC),
   parameter int              FLUSH_CYCLES = 2,
   parameter int              CNT_W        = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall_req,
   input  logic             branch_taken,
   input  logic [XLEN-1:0]  branch_target,
   input  logic             imem_ready,
   input  logic             halt_req,
   output logic [XLEN-1:0]  pc,
   output logic             if_valid,
   output logic             flush_ifid,
   output logic             flush_idex,
   output logic             halted,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam logic [2:0] FLUSH_LD = 3'(FLUSH_CYCLES);

   seq_state_t      state;
   seq_state_t      state_nxt;
   logic [XLEN-1:0] pc_nxt;
   logic [2:0]      fcnt;
   logic [2:0]      fcnt_nxt;
   logic            stall_en;
   logic            flush_en;

   always_comb begin
      state_nxt = state;
      pc_nxt    = pc;
      fcnt_nxt  = fcnt;
      stall_en  = 1'b0;
      if_valid  = 1'b0;
      case (state)
         ST_BOOT: begin
            state_nxt = ST_RUN;
         end
         ST_RUN: begin
            if_valid = imem_ready & ~stall_req;
            if (halt_req) begin
               state_nxt = ST_HALT;
            end else if (branch_taken) begin
               pc_nxt    = branch_target;
               fcnt_nxt  = FLUSH_LD;
               state_nxt = ST_FLUSH;
            end else if (stall_req || !imem_ready) begin
               stall_en = 1'b1;
            end else begin
               pc_nxt = pc + XLEN'(1);
            end
         end
         ST_FLUSH: begin
            // A redirect arriving mid-flush restarts the bubble window.
            if (halt_req) begin
               state_nxt = ST_HALT;
            end else if (branch_taken) begin
               pc_nxt   = branch_target;
               fcnt_nxt = FLUSH_LD;
            end else if (fcnt == 3'd1) begin
               state_nxt = ST_RUN;
            end else begin
               fcnt_nxt = fcnt - 3'd1;
            end
         end
         ST_HALT: begin
            state_nxt = ST_HALT;
         end
         default: begin
            state_nxt = ST_BOOT;
         end
      endcase
   end

   assign flush_en = (state == ST_FLUSH);

   // Strobes and halted are registered from the next state so they line up with it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_BOOT;
         pc         <= RESET_PC;
         fcnt       <= '0;
         flush_ifid <= 1'b0;
         flush_idex <= 1'b0;
         halted     <= 1'b0;
      end else begin
         state      <= state_nxt;
         pc         <= pc_nxt;
         fcnt       <= fcnt_nxt;
         flush_ifid <= (state_nxt == ST_FLUSH);
         flush_idex <= (state_nxt == ST_FLUSH);
         halted     <= (state_nxt == ST_HALT);
      end
   end

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk (clk),
      .rst (rst),
      .en  (stall_en),
      .cnt (stall_cnt)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk (clk),
      .rst (rst),
      .en  (flush_en),
      .cnt (flush_cnt)
   );

endmodule
`default_nettype wire
